fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue on the consumer side of the IF stage: it accepts the {PC, Instruction} pair from IF each cycle and presents entries in order to the ID stage. It decouples IF from ID stalls by buffering up to DEPTH fetched instructions. It drives `freeze` back to IF when full. On a taken branch it discards all wrong-path entries.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  IF presents a fetched instruction this cycle.
- `in_pc`  input  32  PC+4 value from IF, stored with the entry.
- `in_instr`  input  32  instruction word from IF.
- `flush`  input  1  branch taken; discard all entries and the same-cycle input.
- `out_ready`  input  1  ID consumes the head entry this cycle (ID not stalled).
- `out_valid`  output  1  head entry is valid.
- `out_pc`  output  32  head entry PC.
- `out_instr`  output  32  head entry instruction.
- `freeze`  output  1  queue full; IF must hold its PC register.
- `count`  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with read pointer `rd_ptr` and write pointer `wr_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy counter.
- Push: occurs when `in_valid && !full && !flush`. Writes {in_pc, in_instr} at `wr_ptr`, then `wr_ptr` increments.
- Pop: occurs when `out_valid && out_ready && !flush`. `rd_ptr` increments.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Full condition: `full = (count == DEPTH)`, and `freeze = full`.
  - A push is never accepted while full, even if a pop occurs in the same cycle.
  - A frozen IF re-presents the same instruction, so this rule guarantees no duplicate and no loss.
- Empty condition: `count == 0`. In that case `out_valid` is 0.
  - `out_pc` and `out_instr` are then don't-care but must be stable, not X-propagating; they show the stale array entry.
- Flush:
  - Next cycle: `count` is 0 and `rd_ptr` equals `wr_ptr`.
  - The same-cycle input is dropped and no pop is counted.
  - Flush has priority over push and pop.
- Output is show-ahead: `out_pc` and `out_instr` are a combinational read of the array at `rd_ptr`.
- Storage array is not reset; only pointers and the counter are reset.

## Timing
- Reset values (asynchronous, immediate):
  - `rd_ptr` = 0, `wr_ptr` = 0, `count` = 0.
  - `out_valid` = 0, `freeze` = 0.
- Latency: a push in cycle N gives `out_valid` = 1 in cycle N+1 (see the bypass feature under Configuration).
- Throughput: one push and one pop per cycle sustained.
- `freeze` is asserted in the cycle after the push that fills the queue. It deasserts in the cycle after the first pop from full.
- Reset asserted mid-operation: all entries are lost immediately. After release, the first accepted push goes to entry 0.
- Flush while full: `freeze` drops the next cycle. IF loads `BranchAddr` in the same edge as the flush; the following fetch is accepted normally.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count == 0` and `in_valid && !flush`, `out_valid` = 1 and `out_pc`/`out_instr` = `in_pc`/`in_instr` combinationally (zero-latency).
  - If `out_ready` is also 1, the instruction is consumed without being written and `count` stays 0.
  - If `out_ready` is 0, it is written as a normal push.
- `FETCH_QUEUE_BYPASS_EN` undefined: the path is fully registered and latency is exactly 1 cycle as stated in Timing.

## Structure
- Shared pipeline package holds:
  - `INSTR_W` = 32 and `PC_W` = 32.
  - Typedef `fetch_entry_t` {pc, instr}.
  - Default `FETCH_QUEUE_DEPTH` = 4.
- One sub-module, `fetch_queue_mem`: DEPTH x `fetch_entry_t` register array, synchronous write and asynchronous read, no reset.
- Pointer, counter and flag logic lives in `fetch_queue`.

## Test plan
- Reset then idle: after `rst` is released with `in_valid` = 0 → `out_valid` = 0, `freeze` = 0, `count` = 0 for 10 cycles.
- Fill with ID stalled: push PCs 4, 8, 12, 16 with `out_ready` = 0.
  - `count` = 4 and `freeze` = 1 after the 4th push.
  - A 5th instruction (PC 20) is not accepted until one pop occurs, then appears in order.
- Streaming: `in_valid` = 1 and `out_ready` = 1 for 20 cycles with PCs 4..80 → outputs in order, `count` steady at 1.
  - With `FETCH_QUEUE_BYPASS_EN` defined, `count` stays 0.
- Flush with queue at 3 and push in the same cycle (PC 0x40) → next cycle `count` = 0, `out_valid` = 0.
  - The next push (PC 0x104) appears as head one cycle later.
- Flush while full and `out_ready` = 1 → no pop counted, `freeze` = 0 and `count` = 0 next cycle.
- Wrap-around and reset: run 3×DEPTH push/pop mixes checking FIFO order against a scoreboard.
  - Assert `rst` mid-stream → `out_valid` and `count` clear immediately.
  - Post-reset PC 4 is the head.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-pipeline types: entry layout and default queue depth.
package fetch_queue_pkg;
    localparam int INSTR_W           = 32;
    localparam int PC_W              = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// IF/ID handshake bundle around the fetch queue; master is the pipeline side, slave is the queue.
interface fetch_queue_if #(
    parameter int DEPTH = fetch_queue_pkg::FETCH_QUEUE_DEPTH
);
    import fetch_queue_pkg::*;

    logic                   in_valid;
    logic [PC_W-1:0]        in_pc;
    logic [INSTR_W-1:0]     in_instr;
    logic                   flush;
    logic                   out_ready;
    logic                   out_valid;
    logic [PC_W-1:0]        out_pc;
    logic [INSTR_W-1:0]     out_instr;
    logic                   freeze;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  out_valid, out_pc, out_instr, freeze, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output out_valid, out_pc, out_instr, freeze, count
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fetch_queue_mem #(
    parameter int  DEPTH = fetch_queue_pkg::FETCH_QUEUE_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [PTR_W-1:0]             wr_addr_i,
    input  fetch_queue_pkg::fetch_entry_t wr_data_i,
    input  logic [PTR_W-1:0]             rd_addr_i,
    output fetch_queue_pkg::fetch_entry_t rd_data_o
);
    import fetch_queue_pkg::*;

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fetch_queue.sv
// In-order fetch queue between IF and ID with full-freeze and branch flush.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = fetch_queue_pkg::FETCH_QUEUE_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    import fetch_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic         full, empty, byp, byp_take;
    logic         out_valid, push, pop, wr_en, rd_en;
    fetch_entry_t wr_entry, head;

    assign wr_entry.pc    = bus.in_pc;
    assign wr_entry.instr = bus.in_instr;

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head)
    );

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp   = empty && bus.in_valid && !bus.flush;
`endif
        out_valid = !empty || byp;
        // Full blocks the push even if the head leaves this cycle; IF re-presents it.
        push     = bus.in_valid && !full && !bus.flush;
        pop      = out_valid && bus.out_ready && !bus.flush;
        byp_take = byp && bus.out_ready;
        wr_en    = push && !byp_take;
        rd_en    = pop && !empty;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.freeze    = full;
    assign bus.count     = count_q;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bus.out_pc    = byp ? bus.in_pc    : head.pc;
    assign bus.out_instr = byp ? bus.in_instr : head.instr;
`else
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus hand-computed vector table.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fetch_entry_t model[$];

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        int          exp_cnt;
        logic        exp_frz;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0] ^ 16'h5A3C, ~pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; head checked before the edge, state checked after it.
    task automatic cyc(input logic iv, input logic [31:0] pc, input logic fl, input logic rdy);
        fetch_entry_t e;
        bit fullm;
        bit byp;
        e.pc    = pc;
        e.instr = mk_instr(pc);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = e.instr;
        bus.flush     = fl;
        bus.out_ready = rdy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (model.size() == 0) && iv && !fl;
`endif
        if (byp) begin
            chk("byp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("byp_pc", bus.out_pc, pc);
        end else if (model.size() > 0) begin
            chk("head_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("head_pc", bus.out_pc, model[0].pc);
            chk("head_instr", bus.out_instr, model[0].instr);
        end else begin
            chk("empty_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        fullm = (model.size() == DEPTH);
        if (fl) begin
            model.delete();
        end else if (!(byp && rdy)) begin
            if (rdy && model.size() > 0) void'(model.pop_front());
            if (iv && !fullm) model.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        chk("count", {29'b0, bus.count}, model.size());
        chk("freeze", {31'b0, bus.freeze}, (model.size() == DEPTH) ? 32'd1 : 32'd0);
        chk("valid", {31'b0, bus.out_valid}, (model.size() > 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset then idle
        #2;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'b0, bus.count}, 32'd0);
        chk("rst_freeze", {31'b0, bus.freeze}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Fill with ID stalled, blocked 5th fetch, drain in order
        tbl.push_back('{1'b1, 32'd4,  1'b0, 1'b0, 1, 1'b0});
        tbl.push_back('{1'b1, 32'd8,  1'b0, 1'b0, 2, 1'b0});
        tbl.push_back('{1'b1, 32'd12, 1'b0, 1'b0, 3, 1'b0});
        tbl.push_back('{1'b1, 32'd16, 1'b0, 1'b0, 4, 1'b1});
        tbl.push_back('{1'b1, 32'd20, 1'b0, 1'b1, 3, 1'b0});
        tbl.push_back('{1'b1, 32'd20, 1'b0, 1'b0, 4, 1'b1});
        tbl.push_back('{1'b0, 32'd0,  1'b0, 1'b1, 3, 1'b0});
        tbl.push_back('{1'b0, 32'd0,  1'b0, 1'b1, 2, 1'b0});
        tbl.push_back('{1'b0, 32'd0,  1'b0, 1'b1, 1, 1'b0});
        tbl.push_back('{1'b0, 32'd0,  1'b0, 1'b1, 0, 1'b0});
        foreach (tbl[i]) begin
            cyc(tbl[i].iv, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
            chk("tbl_count", {29'b0, bus.count}, tbl[i].exp_cnt);
            chk("tbl_freeze", {31'b0, bus.freeze}, {31'b0, tbl[i].exp_frz});
        end

        // Streaming
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 32'(4 * i), 1'b0, 1'b1);
`ifdef FETCH_QUEUE_BYPASS_EN
            chk("stream_count", {29'b0, bus.count}, 32'd0);
`else
            chk("stream_count", {29'b0, bus.count}, 32'd1);
`endif
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush at occupancy 3 with a same-cycle push
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        cyc(1'b1, 32'h18, 1'b0, 1'b0);
        chk("pre_flush_count", {29'b0, bus.count}, 32'd3);
        cyc(1'b1, 32'h40, 1'b1, 1'b0);
        chk("flush_count", {29'b0, bus.count}, 32'd0);
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc(1'b1, 32'h104, 1'b0, 1'b0);
        chk("post_flush_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("post_flush_head", bus.out_pc, 32'h104);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Flush while full with ID ready
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(32'h80 + 4 * i), 1'b0, 1'b0);
        chk("full_freeze", {31'b0, bus.freeze}, 32'd1);
        cyc(1'b1, 32'h200, 1'b1, 1'b1);
        chk("flush_full_freeze", {31'b0, bus.freeze}, 32'd0);
        chk("flush_full_count", {29'b0, bus.count}, 32'd0);
        cyc(1'b1, 32'h300, 1'b0, 1'b0);
        chk("branch_target_count", {29'b0, bus.count}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        // Wrap-around with random push/pop/flush mix
        for (int i = 0; i < 3 * DEPTH * 3; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 32'(32'h1000 + 4 * i),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream
        cyc(1'b1, 32'h2000, 1'b0, 1'b0);
        cyc(1'b1, 32'h2004, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_count", {29'b0, bus.count}, 32'd0);
        chk("midrst_freeze", {31'b0, bus.freeze}, 32'd0);
        model.delete();
        @(posedge clk);
        #3 rst = 1'b1;
        cyc(1'b1, 32'd4, 1'b0, 1'b0);
        chk("postrst_head", bus.out_pc, 32'd4);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
